// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned CSUM_W     = 8;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word shifter with a byte index that flags the 4th byte of each word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        shift_en,
  input  logic        clear,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [23:0] r_sr;
  logic [1:0]  r_idx;

  // The three earlier bytes are stored; the 4th comes straight from byte_in so the
  // finished word is available in the same cycle as the final shift.
  assign word          = {r_sr, byte_in};
  assign word_complete = shift_en && (r_idx == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr  <= '0;
      r_idx <= '0;
    end else if (clear) begin
      r_idx <= '0;
    end else if (shift_en) begin
      r_sr  <= {r_sr[15:0], byte_in};
      r_idx <= r_idx + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: fills instruction memory from a checksummed byte frame and holds the core in reset until it passes.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wd,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t r_state;
  state_t w_next;

  logic              w_xfer;
  logic              w_hdr;
  logic              w_shift;
  logic              w_last_word;
  logic [31:0]       w_word;
  logic              w_word_complete;

  logic [CNT_W-1:0]  r_n_words;
  logic [CNT_W-1:0]  r_word_cnt;
  logic [CSUM_W-1:0] r_xor;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wd;
  logic              r_cpu_reset;
  logic              r_done;
  logic              r_error;

  assign rx_ready    = (r_state != DONE);
  assign w_xfer      = rx_valid && rx_ready;
  assign w_hdr       = w_xfer && ((r_state == IDLE) || (r_state == ERROR));
  assign w_shift     = w_xfer && (r_state == DATA);
  assign w_last_word = w_word_complete && ((r_word_cnt + CNT_W'(1)) == r_n_words);

  word_assembler u_asm (
    .clk           (clk),
    .reset         (reset),
    .byte_in       (rx_data),
    .shift_en      (w_shift),
    .clear         (w_hdr),
    .word          (w_word),
    .word_complete (w_word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE, ERROR: if (w_xfer) w_next = DATA;
      DATA:        if (w_xfer && w_last_word) w_next = CHECK;
      CHECK:       if (w_xfer) w_next = (rx_data == r_xor) ? DONE : ERROR;
      DONE:        w_next = DONE;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_words   <= '0;
      r_word_cnt  <= '0;
      r_xor       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wd        <= '0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (w_hdr) begin
        r_n_words  <= {1'b0, rx_data[ADDR_W-1:0]} + CNT_W'(1);
        r_word_cnt <= '0;
        r_xor      <= '0;
        r_addr     <= '0;
      end
      if (w_shift) begin
        r_xor <= r_xor ^ rx_data;
        if (w_word_complete) begin
          r_we       <= 1'b1;
          r_addr     <= r_word_cnt[ADDR_W-1:0];
          r_wd       <= w_word;
          r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
      end
      // Status follows the state being entered, so it lands one cycle after the checksum byte.
      r_done      <= (w_next == DONE);
      r_cpu_reset <= (w_next != DONE);
      r_error     <= (w_next == ERROR);
    end
  end

  assign imem_we   = r_we;
  assign imem_addr = r_addr;
  assign imem_wd   = r_wd;
  assign cpu_reset = r_cpu_reset;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: constant vector table, reference frame model and multi-cycle corner cases.
module tb_imem_loader;

  localparam int unsigned AW = 6;

  typedef logic [7:0] bq_t[$];
  typedef logic [AW+31:0] wr_t;

  typedef struct {
    logic [7:0]  hdr;
    logic [31:0] data;
    logic [7:0]  csum;
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wd;
  logic          cpu_reset;
  logic          done;
  logic          error;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   spurious = 0;
  logic prev_xfer = 1'b0;
  wr_t  obs[$];
  wr_t  exp_q[$];
  bit   exp_pass;
  vec_t vecs[5];

  imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wd   (imem_wd),
    .cpu_reset (cpu_reset),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) prev_xfer <= rx_valid && rx_ready && !reset;

  always @(negedge clk) begin
    if (imem_we) begin
      obs.push_back({imem_addr, imem_wd});
      if (!prev_xfer) spurious++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: words, addresses and verdict derived directly from the frame bytes.
  task automatic model_frame(input bq_t f);
    int n;
    logic [7:0] x;
    logic [31:0] w;
    exp_q.delete();
    n = (int'(f[0]) % (1 << AW)) + 1;
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 32'(f[1+4*k]) * 32'h0100_0000 + 32'(f[2+4*k]) * 32'h0001_0000
        + 32'(f[3+4*k]) * 32'h0000_0100 + 32'(f[4+4*k]);
      exp_q.push_back({AW'(k), w});
    end
    for (int i = 1; i <= 4 * n; i++) x = x ^ f[i];
    exp_pass = (f[4*n+1] == x);
  endtask

  task automatic build_frame(input int n, input bit good, output bq_t f);
    logic [7:0] x;
    f = {};
    x = 8'h00;
    f.push_back(8'(n - 1) | 8'($urandom_range(0, 3) << AW));
    for (int i = 0; i < 4 * n; i++) begin
      f.push_back(8'($urandom));
      x = x ^ f[f.size()-1];
    end
    f.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
  endtask

  task automatic do_reset(input bit hold_valid);
    @(negedge clk);
    reset = 1'b1;
    rx_valid = hold_valid;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    obs.delete();
    spurious = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data = b;
    t = 0;
    while (!rx_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 64'(rx_ready), 64'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  // Returns at the first negedge after the last transfer, where done/cpu_reset must already be updated.
  task automatic send_frame(input bq_t f, input int gmax);
    for (int i = 0; i < f.size(); i++) send_byte(f[i], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic compare_writes(input string tag);
    @(negedge clk);
    check({tag, "_wr_count"}, 64'(obs.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), 64'(obs[i]), 64'(exp_q[i]));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_we"}, 64'(imem_we), 64'd0);
    check({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check({tag, "_wd"}, 64'(imem_wd), 64'd0);
    check({tag, "_cpu_reset"}, 64'(cpu_reset), 64'd1);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
  endtask

  initial begin
    bq_t f;
    bq_t good_f;
    logic [31:0] d;
    int rdy_seen;
    int not_done;
    int obs0;

    vecs[0] = '{8'h00, 32'h2010_0005, 8'h35, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 32'hDEAD_BEEF, 8'h22, 1'b1, 1'b0};
    vecs[2] = '{8'hC0, 32'hFFFF_FFFF, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h00, 32'h1234_5678, 8'h00, 1'b0, 1'b1};
    vecs[4] = '{8'h40, 32'h0102_0304, 8'h04, 1'b1, 1'b0};

    do_reset(1'b0);
    check_reset_vals("por");

    // One-word frames from the constant table.
    for (int v = 0; v < 5; v++) begin
      do_reset(1'b0);
      f = {};
      d = vecs[v].data;
      f.push_back(vecs[v].hdr);
      for (int b = 0; b < 4; b++) f.push_back(d[31-8*b -: 8]);
      f.push_back(vecs[v].csum);
      send_frame(f, 0);
      check($sformatf("vec%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d_error", v), 64'(error), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_cpu_reset", v), 64'(cpu_reset), 64'(!vecs[v].exp_done));
      @(negedge clk);
      check($sformatf("vec%0d_wr_count", v), 64'(obs.size()), 64'd1);
      if (obs.size() > 0) check($sformatf("vec%0d_wr", v), 64'(obs[0]), {26'd0, 6'd0, vecs[v].data});
    end

    // Full 64-word frame, bytes 0..255, XOR of all is 0.
    do_reset(1'b0);
    f = {};
    f.push_back(8'h3F);
    for (int i = 0; i < 256; i++) f.push_back(8'(i));
    f.push_back(8'h00);
    model_frame(f);
    send_frame(f, 0);
    check("full_done", 64'(done), 64'd1);
    check("full_cpu_reset", 64'(cpu_reset), 64'd0);
    compare_writes("full");
    if (obs.size() == 64) check("full_last_word", 64'(obs[63]), {26'd0, 6'd63, 32'hFCFD_FEFF});

    // Bad checksum, then the good frame without an intervening reset.
    do_reset(1'b0);
    f = {8'h00, 8'h20, 8'h10, 8'h00, 8'h05, 8'h00};
    send_frame(f, 0);
    check("bad_error", 64'(error), 64'd1);
    check("bad_cpu_reset", 64'(cpu_reset), 64'd1);
    check("bad_done", 64'(done), 64'd0);
    check("bad_rx_ready", 64'(rx_ready), 64'd1);
    obs.delete();
    good_f = {8'h00, 8'h20, 8'h10, 8'h00, 8'h05, 8'h35};
    model_frame(good_f);
    send_byte(good_f[0], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("retry_hdr_error_clear", 64'(error), 64'd0);
    check("retry_hdr_cpu_reset", 64'(cpu_reset), 64'd1);
    for (int i = 1; i < good_f.size(); i++) send_byte(good_f[i], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    check("retry_done", 64'(done), 64'd1);
    check("retry_error", 64'(error), 64'd0);
    compare_writes("retry");

    // Bytes offered in DONE must be refused.
    rdy_seen = 0;
    not_done = 0;
    obs0 = obs.size();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data = 8'($urandom);
      if (rx_ready) rdy_seen++;
      if (!done) not_done++;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    check("done_rx_ready_seen", 64'(rdy_seen), 64'd0);
    check("done_dropped", 64'(not_done), 64'd0);
    check("done_no_writes", 64'(obs.size()), 64'(obs0));

    // 3-word frame gap-free, then with random gaps: identical writes, no spurious pulses.
    build_frame(3, 1'b1, f);
    model_frame(f);
    do_reset(1'b0);
    send_frame(f, 0);
    check("gap0_done", 64'(done), 64'd1);
    compare_writes("gap0");
    do_reset(1'b0);
    send_frame(f, 5);
    check("gaps_done", 64'(done), 64'd1);
    compare_writes("gaps");
    check("gaps_spurious_we", 64'(spurious), 64'd0);

    // Random frames of random length and verdict.
    for (int r = 0; r < 6; r++) begin
      build_frame(int'($urandom_range(1, 8)), bit'($urandom_range(0, 1)), f);
      model_frame(f);
      do_reset(1'b0);
      send_frame(f, 3);
      check($sformatf("rnd%0d_done", r), 64'(done), 64'(exp_pass));
      check($sformatf("rnd%0d_error", r), 64'(error), 64'(!exp_pass));
      check($sformatf("rnd%0d_cpu_reset", r), 64'(cpu_reset), 64'(!exp_pass));
      compare_writes($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_spurious_we", r), 64'(spurious), 64'd0);
    end

    // Reset after 6 bytes of a 2-word frame, with a byte held valid during reset.
    do_reset(1'b0);
    build_frame(2, 1'b1, f);
    for (int i = 0; i < 6; i++) send_byte(f[i], 0);
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("partial_wr_count", 64'(obs.size()), 64'd1);
    do_reset(1'b1);
    check_reset_vals("midrst");
    model_frame(f);
    send_frame(f, 2);
    check("midrst_done", 64'(done), 64'd1);
    compare_writes("midrst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
